// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCWrite,
  input  logic               IF_ID_Write,
  input  logic               IF_Flush,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [ADDR_W-1:0]  IF_ID_PC_plus4,
  output logic               IF_ID_Valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count,
`endif
  output logic [ADDR_W-1:0]  fetch_pc
);

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  req_pc_reg, req_pc_next;
  logic               stale_reg, stale_next;
  logic               hold_valid_reg, hold_valid_next;
  logic [INSTR_W-1:0] hold_instr_reg, hold_instr_next;
  logic [INSTR_W-1:0] id_instr_reg, id_instr_next;
  logic [ADDR_W-1:0]  id_pc4_reg, id_pc4_next;
  logic               id_valid_reg, id_valid_next;

  logic               deliver;
  logic [INSTR_W-1:0] deliver_instr;
  logic [ADDR_W-1:0]  deliver_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FETCH;
      pc_reg         <= RESET_PC;
      req_pc_reg     <= '0;
      stale_reg      <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_instr_reg <= '0;
      id_instr_reg   <= '0;
      id_pc4_reg     <= '0;
      id_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      req_pc_reg     <= req_pc_next;
      stale_reg      <= stale_next;
      hold_valid_reg <= hold_valid_next;
      hold_instr_reg <= hold_instr_next;
      id_instr_reg   <= id_instr_next;
      id_pc4_reg     <= id_pc4_next;
      id_valid_reg   <= id_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    req_pc_next     = req_pc_reg;
    stale_next      = stale_reg;
    hold_valid_next = hold_valid_reg;
    hold_instr_next = hold_instr_reg;
    id_instr_next   = id_instr_reg;
    id_pc4_next     = id_pc4_reg;
    id_valid_next   = id_valid_reg;
    imem_req        = 1'b0;
    deliver         = 1'b0;
    deliver_instr   = '0;
    deliver_pc4     = '0;

    if (IF_Flush) begin
      // Redirect wins over both stalls; an in-flight response is marked stale.
      pc_next         = redirect_target;
      hold_valid_next = 1'b0;
      id_instr_next   = '0;
      id_valid_next   = 1'b0;
      if (state_reg == ST_WAIT && !imem_rvalid) begin
        stale_next = 1'b1;
        state_next = ST_WAIT;
      end else begin
        stale_next = 1'b0;
        state_next = ST_FETCH;
      end
    end else begin
      case (state_reg)
        ST_FETCH: begin
          imem_req = rst_n & PCWrite & ~hold_valid_reg;
          if (imem_req && imem_ready) begin
            req_pc_next = pc_reg;
            pc_next     = pc_reg + ADDR_W'(4);
            state_next  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stale_reg) begin
              stale_next = 1'b0;
              state_next = ST_FETCH;
            end else if (IF_ID_Write) begin
              deliver       = 1'b1;
              deliver_instr = imem_rdata;
              deliver_pc4   = req_pc_reg + ADDR_W'(4);
              state_next    = ST_FETCH;
            end else begin
              hold_instr_next = imem_rdata;
              hold_valid_next = 1'b1;
              state_next      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // req_pc_reg is untouched while holding, so it still tags the buffered word.
          if (IF_ID_Write) begin
            deliver         = 1'b1;
            deliver_instr   = hold_instr_reg;
            deliver_pc4     = req_pc_reg + ADDR_W'(4);
            hold_valid_next = 1'b0;
            state_next      = ST_FETCH;
          end
        end
        default: state_next = ST_FETCH;
      endcase

      if (IF_ID_Write) begin
        id_instr_next = deliver ? deliver_instr : '0;
        id_valid_next = deliver;
        if (deliver) id_pc4_next = deliver_pc4;
      end
    end
  end

  assign imem_addr      = pc_reg;
  assign fetch_pc       = pc_reg;
  assign IF_ID_Instr    = id_instr_reg;
  assign IF_ID_PC_plus4 = id_pc4_reg;
  assign IF_ID_Valid    = id_valid_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (!IF_ID_Write) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (IF_Flush)     flush_count_reg  <= flush_count_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`endif

endmodule
